header_frame_rx: RTL and testbench
==================================

Name: header_frame_rx

Overview:
- Assembles the 640-bit mining block header from the UART receive byte stream and feeds `minerControl`.
- Sits between the UART core's RX byte output and the miner/processor header inputs.
- Hunts for a sync byte, then collects 80 payload bytes and an XOR checksum. It commits the header atomically only on a good checksum.
- Emits a one-cycle `header_valid` strobe. The top level uses this strobe to restart mining and the processor.

Parameters:
- HEADER_BYTES, 80, payload bytes per frame; header width = 8*HEADER_BYTES.
- SYNC_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYCLES, 5000000, idle clocks mid-frame before abort (100 ms at 50 MHz).

Ports:
- clock  in  1  system clock (`uartClock` domain).
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte, meaningful only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte; may be high every cycle.
- blockHeader  out  8*HEADER_BYTES  last committed header; first payload byte at [639:632], last at [7:0].
- header_valid  out  1  one-cycle pulse when blockHeader updates.
- frame_error  out  1  one-cycle pulse on checksum mismatch.
- timeout_error  out  1  one-cycle pulse on mid-frame timeout.
- byteCount  out  32  total rx_valid bytes since reset; wraps mod 2^32.
- busy  out  1  high while in PAYLOAD or CHECK.

Behaviour:
- Reset values:
  - blockHeader=0, header_valid=0, frame_error=0, timeout_error=0, byteCount=0, busy=0.
  - State=IDLE; internal shift register, index, checksum and timer all cleared.
- Reset asserted mid-frame: the partial frame is discarded; blockHeader returns to 0.
- All outputs are registered.
- byteCount increments on every rx_valid in any state, including discarded and garbage bytes.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> PAYLOAD; index=0, checksum=0, timer=0.
  - Any other byte is ignored.
- PAYLOAD:
  - Each rx_valid shifts rx_data into the low byte of the internal shift register (left shift by 8) and sets checksum ^= rx_data.
  - SYNC_BYTE in payload is ordinary data and does not resync.
  - Index HEADER_BYTES-1 received -> CHECK.
- CHECK:
  - Next rx_valid is the checksum byte; state -> IDLE.
  - If rx_data==checksum: blockHeader <= shift register, and header_valid=1 on the same edge. Latency is one clock after the checksum byte's rx_valid cycle.
  - Else: frame_error=1 on that edge; blockHeader unchanged.
- Timer (PAYLOAD/CHECK only):
  - Reset to 0 on each accepted byte; increments every clock without rx_valid.
  - When the timer reaches TIMEOUT_CYCLES-1 with no rx_valid: timeout_error=1 on the next edge, state -> IDLE, partial frame discarded, blockHeader unchanged.
  - rx_valid in the same cycle as expiry wins: the byte is accepted and the timer resets.
- Back-to-back frames: a sync byte arriving the cycle immediately after the checksum byte is accepted (state is already IDLE).
- header_valid, frame_error and timeout_error are mutually exclusive per cycle.
- busy=1 iff state is PAYLOAD or CHECK.
- Timer width = clog2(TIMEOUT_CYCLES). Index width = clog2(HEADER_BYTES).

Decomposition:
- Shared package/include `miner_defs`:
  - Constants HEADER_BYTES=80, HEADER_W=640, SYNC_BYTE.
  - State encoding localparams IDLE=2'd0, PAYLOAD=2'd1, CHECK=2'd2.
- One natural sub-module: `frame_timeout_timer` (load-on-byte, count-when-active, one-cycle expiry pulse).
- FSM, shift register and checksum stay in the top of this block.

Test Plan:
1. TIMEOUT_CYCLES=100.
   - Stimulus: 0xA5, payload bytes 0x00..0x4F (one per 16 clocks), checksum 0x00.
   - Required: header_valid pulses once, one clock after the checksum strobe; blockHeader[639:632]=0x00, [31:0]=0x4C4D4E4F; byteCount=82; busy=0 afterwards.
2. Same frame with checksum 0x01.
   - Required: frame_error pulses once; header_valid stays 0; blockHeader keeps its previous value (0 after reset, or case-1 value); byteCount=82.
3. Timeout.
   - Stimulus: 0xA5 plus 10 payload bytes, then silence.
   - Required: timeout_error pulses exactly 100 clocks after the last byte's edge; busy drops.
   - Follow-up: a full good frame is then accepted normally.
4. Garbage before sync.
   - Stimulus: 0x00, 0xFF, 0x5A, then the case-1 frame with 0xA5 also placed at payload index 5.
   - Required: header_valid pulses once; blockHeader byte 5 = 0xA5; byteCount=85.
5. Back-to-back frames with rx_valid held high continuously.
   - Stimulus: two good frames, the second with payload 0x4F..0x00 and checksum 0x00.
   - Required: two header_valid pulses exactly 82 clocks apart; final blockHeader[31:0]=0x03020100.
6. Reset mid-payload.
   - Stimulus: reset for 1 clock at payload index 40, then the case-1 frame.
   - Required: all outputs 0 immediately after reset; no spurious pulses; header_valid pulses once; byteCount=82.

Source files
------------

// File: rtl/header_frame_rx_pkg.sv
// Shared definitions for the block header frame receiver.
// Holds the frame geometry, the sync marker, the default timeout and the
// receiver state encoding used by header_frame_rx and its helpers.
package header_frame_rx_pkg;

   localparam int         HEADER_BYTES           = 80;
   localparam int         HEADER_W               = 8 * HEADER_BYTES;
   localparam logic [7:0] SYNC_BYTE              = 8'hA5;
   localparam int         TIMEOUT_CYCLES_DEFAULT = 5000000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } rxState_t;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int widthOf(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/header_frame_rx_if.sv
// Byte-in / header-out bundle of the block header frame receiver.
// master: byte source (drives rx_data/rx_valid, observes results).
// slave : receiver (consumes bytes, drives header, strobes, byteCount, busy).
interface header_frame_rx_if
   import header_frame_rx_pkg::*;
   ();

   logic [7:0]          rx_data;
   logic                rx_valid;
   logic [HEADER_W-1:0] blockHeader;
   logic                header_valid;
   logic                frame_error;
   logic                timeout_error;
   logic [31:0]         byteCount;
   logic                busy;

   modport master (
      output rx_data, rx_valid,
      input  blockHeader, header_valid, frame_error, timeout_error, byteCount, busy
   );

   modport slave (
      input  rx_data, rx_valid,
      output blockHeader, header_valid, frame_error, timeout_error, byteCount, busy
   );

endinterface

// File: rtl/header_frame_rx_timer.sv
// Mid-frame inactivity timer: counts idle clocks while a frame is open.
// Latency: expire is combinational, true in the cycle whose edge ends the frame.
// No backpressure: a byte in the expiry cycle reloads the timer and suppresses expiry.
// Ports: clock, reset (sync, active-high), active (frame open),
//        load (byte accepted this cycle), expire (abort on this edge).
module frame_timeout_timer
   import header_frame_rx_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic active,
   input  logic load,
   output logic expire
);

   localparam int            TW   = widthOf(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] idleCount;

   // idleCount holds the number of idle clocks since the last byte, so
   // reaching LAST with no byte means this edge is the TIMEOUT_CYCLES-th idle one.
   assign expire = active && !load && (idleCount == LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         idleCount <= '0;
      end else if (!active || load || expire) begin
         idleCount <= '0;
      end else begin
         idleCount <= idleCount + 1'b1;
      end
   end

endmodule

// File: rtl/header_frame_rx.sv
// Assembles the 640-bit block header from the UART byte stream (sync, payload, XOR checksum).
// Latency: header_valid/frame_error one clock after the checksum byte's rx_valid cycle.
// No backpressure: a byte may arrive every cycle and is always consumed.
// Ports: clock, reset (sync, active-high), bus (header_frame_rx_if.slave):
//        rx_data/rx_valid in; blockHeader, header_valid, frame_error,
//        timeout_error, byteCount, busy out (all registered).
module header_frame_rx
   import header_frame_rx_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   header_frame_rx_if.slave bus
);

   localparam int            IW         = widthOf(HEADER_BYTES);
   localparam logic [IW-1:0] LAST_INDEX = IW'(HEADER_BYTES - 1);

   rxState_t            state;
   logic [IW-1:0]       index;
   logic [7:0]          checksum;
   logic [HEADER_W-1:0] shiftReg;
   logic [HEADER_W-1:0] blockHeader;
   logic                headerValid;
   logic                frameError;
   logic                timeoutError;
   logic [31:0]         byteCount;
   logic                busy;
   logic                timerExpire;

   // busy is the registered "frame open" flag, so it doubles as the timer enable.
   frame_timeout_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .active (busy),
      .load   (bus.rx_valid),
      .expire (timerExpire)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         index        <= '0;
         checksum     <= '0;
         shiftReg     <= '0;
         blockHeader  <= '0;
         headerValid  <= 1'b0;
         frameError   <= 1'b0;
         timeoutError <= 1'b0;
         byteCount    <= '0;
         busy         <= 1'b0;
      end else begin
         headerValid  <= 1'b0;
         frameError   <= 1'b0;
         timeoutError <= 1'b0;

         // Every received byte is counted, whether or not it belongs to a frame.
         if (bus.rx_valid) begin
            byteCount <= byteCount + 32'd1;
         end

         unique case (state)
            IDLE: begin
               if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                  state    <= PAYLOAD;
                  busy     <= 1'b1;
                  index    <= '0;
                  checksum <= '0;
               end
            end

            PAYLOAD: begin
               // A sync value inside the payload is plain data; no resync.
               if (bus.rx_valid) begin
                  shiftReg <= {shiftReg[HEADER_W-9:0], bus.rx_data};
                  checksum <= checksum ^ bus.rx_data;
                  if (index == LAST_INDEX) begin
                     state <= CHECK;
                  end else begin
                     index <= index + 1'b1;
                  end
               end else if (timerExpire) begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  timeoutError <= 1'b1;
               end
            end

            CHECK: begin
               if (bus.rx_valid) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (bus.rx_data == checksum) begin
                     blockHeader <= shiftReg;
                     headerValid <= 1'b1;
                  end else begin
                     frameError  <= 1'b1;
                  end
               end else if (timerExpire) begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  timeoutError <= 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.blockHeader   = blockHeader;
   assign bus.header_valid  = headerValid;
   assign bus.frame_error   = frameError;
   assign bus.timeout_error = timeoutError;
   assign bus.byteCount     = byteCount;
   assign bus.busy          = busy;

endmodule

// File: tb/tb_header_frame_rx.sv
// Bench for header_frame_rx with a byte-level frame model (sync hunt,
// payload queue, XOR over the queue, idle-clock timeout).
module tb_header_frame_rx;
   import header_frame_rx_pkg::*;

   localparam int TMO = 100;
   localparam int HB  = HEADER_BYTES;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   header_frame_rx_if bus ();

   header_frame_rx #(.TIMEOUT_CYCLES(TMO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int nVec  = 0;
   int nMiss = 0;
   int cyc   = 0;
   int cycleErr = 0;      // cycles where DUT outputs disagreed with the model
   int hvCyc[$];
   int feCyc[$];
   int toCyc[$];

   // Reference model state
   bit                  mInFrame;
   logic [7:0]          mFrame[$];
   int                  mQuiet;
   logic [HEADER_W-1:0] mHeader;
   logic [31:0]         mCount;

   logic [7:0] pl [HB];

   function automatic void modelReset();
      mInFrame = 0;
      mFrame.delete();
      mQuiet   = 0;
      mHeader  = '0;
      mCount   = '0;
   endfunction

   function automatic void modelStep(input bit v, input logic [7:0] d,
                                     output bit eHv, output bit eFe, output bit eTo);
      logic [7:0] x;
      eHv = 0; eFe = 0; eTo = 0;
      x = 8'h00;
      if (v) begin
         mCount = mCount + 32'd1;
         if (!mInFrame) begin
            if (d == SYNC_BYTE) begin
               mInFrame = 1;
               mFrame.delete();
               mQuiet = 0;
            end
         end else if (mFrame.size() < HB) begin
            mFrame.push_back(d);
            mQuiet = 0;
         end else begin
            foreach (mFrame[i]) x = x ^ mFrame[i];
            if (x == d) begin
               for (int i = 0; i < HB; i++) mHeader[HEADER_W-1-8*i -: 8] = mFrame[i];
               eHv = 1;
            end else begin
               eFe = 1;
            end
            mInFrame = 0;
         end
      end else if (mInFrame) begin
         mQuiet++;
         if (mQuiet == TMO) begin
            eTo = 1;
            mInFrame = 0;
         end
      end
   endfunction

   function automatic logic [7:0] plXor();
      logic [7:0] x = 8'h00;
      for (int i = 0; i < HB; i++) x = x ^ pl[i];
      return x;
   endfunction

   task automatic clearLogs();
      hvCyc.delete(); feCyc.delete(); toCyc.delete();
   endtask

   task automatic step(input bit v, input logic [7:0] d);
      bit eHv, eFe, eTo;
      bus.rx_valid = v;
      bus.rx_data  = d;
      @(posedge clock); #1;
      cyc++;
      modelStep(v, d, eHv, eFe, eTo);
      if ({bus.header_valid, bus.frame_error, bus.timeout_error} !== {eHv, eFe, eTo} ||
          bus.busy !== mInFrame || bus.byteCount !== mCount || bus.blockHeader !== mHeader)
         cycleErr++;
      if (bus.header_valid === 1'b1)  hvCyc.push_back(cyc);
      if (bus.frame_error === 1'b1)   feCyc.push_back(cyc);
      if (bus.timeout_error === 1'b1) toCyc.push_back(cyc);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic sendByte(input logic [7:0] d, input int minGap, input int maxGap);
      int g = $urandom_range(maxGap, minGap);
      repeat (g) step(1'b0, 8'h00);
      step(1'b1, d);
   endtask

   task automatic sendFrame(input logic [7:0] cs, input int minGap, input int maxGap);
      sendByte(SYNC_BYTE, minGap, maxGap);
      for (int i = 0; i < HB; i++) sendByte(pl[i], minGap, maxGap);
      sendByte(cs, minGap, maxGap);
   endtask

   task automatic doReset();
      reset = 1'b1;
      bus.rx_valid = 1'b0;
      @(posedge clock); #1;
      cyc++;
      reset = 1'b0;
      modelReset();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = SYNC_BYTE;
      repeat (3) @(posedge clock);
      #1;
      nVec++; if (bus.blockHeader !== '0) begin nMiss++; $display("FAIL rst_header got %h want 0", bus.blockHeader[31:0]); end
      nVec++; if (bus.header_valid !== 1'b0) begin nMiss++; $display("FAIL rst_hv got %b want 0", bus.header_valid); end
      nVec++; if (bus.frame_error !== 1'b0) begin nMiss++; $display("FAIL rst_fe got %b want 0", bus.frame_error); end
      nVec++; if (bus.timeout_error !== 1'b0) begin nMiss++; $display("FAIL rst_to got %b want 0", bus.timeout_error); end
      nVec++; if (bus.byteCount !== 32'd0) begin nMiss++; $display("FAIL rst_count got %0d want 0", bus.byteCount); end
      nVec++; if (bus.busy !== 1'b0) begin nMiss++; $display("FAIL rst_busy got %b want 0", bus.busy); end
      reset = 1'b0;
      bus.rx_valid = 1'b0;
      modelReset();
   endtask

   task automatic test_good_frame();
      int e0 = cycleErr;
      int csCyc;
      clearLogs();
      for (int i = 0; i < HB; i++) pl[i] = 8'(i);
      sendFrame(8'h00, 15, 15);
      csCyc = cyc;
      repeat (3) step(1'b0, 8'h00);
      nVec++; if (hvCyc.size() != 1) begin nMiss++; $display("FAIL good_hv_count got %0d want 1", hvCyc.size()); end
      else begin nVec++; if (hvCyc[0] != csCyc) begin nMiss++; $display("FAIL good_hv_latency got cyc %0d want %0d", hvCyc[0], csCyc); end end
      nVec++; if (bus.blockHeader[639:632] !== 8'h00) begin nMiss++; $display("FAIL good_first_byte got %h want 00", bus.blockHeader[639:632]); end
      nVec++; if (bus.blockHeader[31:0] !== 32'h4C4D4E4F) begin nMiss++; $display("FAIL good_last_word got %h want 4C4D4E4F", bus.blockHeader[31:0]); end
      nVec++; if (bus.byteCount !== 32'd82) begin nMiss++; $display("FAIL good_count got %0d want 82", bus.byteCount); end
      nVec++; if (bus.busy !== 1'b0) begin nMiss++; $display("FAIL good_busy got %b want 0", bus.busy); end
      nVec++; if (cycleErr != e0) begin nMiss++; $display("FAIL good_trace got %0d bad cycles want 0", cycleErr - e0); end
   endtask

   task automatic test_bad_checksum();
      int e0 = cycleErr;
      clearLogs();
      for (int i = 0; i < HB; i++) pl[i] = 8'(i);
      sendFrame(8'h01, 15, 15);
      repeat (3) step(1'b0, 8'h00);
      nVec++; if (feCyc.size() != 1) begin nMiss++; $display("FAIL bad_fe_count got %0d want 1", feCyc.size()); end
      nVec++; if (hvCyc.size() != 0) begin nMiss++; $display("FAIL bad_hv_count got %0d want 0", hvCyc.size()); end
      nVec++; if (bus.blockHeader[31:0] !== 32'h4C4D4E4F) begin nMiss++; $display("FAIL bad_header_kept got %h want 4C4D4E4F", bus.blockHeader[31:0]); end
      nVec++; if (bus.byteCount !== 32'd164) begin nMiss++; $display("FAIL bad_count got %0d want 164", bus.byteCount); end
      nVec++; if (cycleErr != e0) begin nMiss++; $display("FAIL bad_trace got %0d bad cycles want 0", cycleErr - e0); end
   endtask

   task automatic test_timeout();
      int e0 = cycleErr;
      int lastCyc;
      logic [31:0] keep = bus.blockHeader[31:0];
      clearLogs();
      sendByte(SYNC_BYTE, 0, 5);
      for (int i = 0; i < 10; i++) sendByte(8'($urandom), 0, 20);
      lastCyc = cyc;
      repeat (150) step(1'b0, 8'h00);
      nVec++; if (toCyc.size() != 1) begin nMiss++; $display("FAIL tmo_count got %0d want 1", toCyc.size()); end
      else begin nVec++; if (toCyc[0] != lastCyc + TMO) begin nMiss++; $display("FAIL tmo_latency got %0d want %0d", toCyc[0] - lastCyc, TMO); end end
      nVec++; if (bus.busy !== 1'b0) begin nMiss++; $display("FAIL tmo_busy got %b want 0", bus.busy); end
      nVec++; if (bus.blockHeader[31:0] !== keep) begin nMiss++; $display("FAIL tmo_header_kept got %h want %h", bus.blockHeader[31:0], keep); end
      for (int i = 0; i < HB; i++) pl[i] = 8'($urandom);
      sendFrame(plXor(), 0, 4);
      step(1'b0, 8'h00);
      nVec++; if (hvCyc.size() != 1) begin nMiss++; $display("FAIL tmo_followup_hv got %0d want 1", hvCyc.size()); end
      nVec++; if (bus.blockHeader !== mHeader) begin nMiss++; $display("FAIL tmo_followup_header got %h want %h", bus.blockHeader[31:0], mHeader[31:0]); end
      nVec++; if (cycleErr != e0) begin nMiss++; $display("FAIL tmo_trace got %0d bad cycles want 0", cycleErr - e0); end
   endtask

   task automatic test_garbage();
      int e0 = cycleErr;
      logic [31:0] cnt0 = mCount;
      clearLogs();
      for (int i = 0; i < HB; i++) pl[i] = 8'(i);
      pl[5] = SYNC_BYTE;
      sendByte(8'h00, 0, 3);
      sendByte(8'hFF, 0, 3);
      sendByte(8'h5A, 0, 3);
      sendFrame(8'hA0, 0, 3);
      step(1'b0, 8'h00);
      nVec++; if (hvCyc.size() != 1) begin nMiss++; $display("FAIL garb_hv got %0d want 1", hvCyc.size()); end
      nVec++; if (bus.blockHeader[599:592] !== 8'hA5) begin nMiss++; $display("FAIL garb_byte5 got %h want A5", bus.blockHeader[599:592]); end
      nVec++; if (bus.byteCount !== cnt0 + 32'd85) begin nMiss++; $display("FAIL garb_count got %0d want %0d", bus.byteCount, cnt0 + 32'd85); end
      nVec++; if (cycleErr != e0) begin nMiss++; $display("FAIL garb_trace got %0d bad cycles want 0", cycleErr - e0); end
   endtask

   task automatic test_back_to_back();
      int e0 = cycleErr;
      clearLogs();
      for (int i = 0; i < HB; i++) pl[i] = 8'(i);
      sendFrame(8'h00, 0, 0);
      for (int i = 0; i < HB; i++) pl[i] = 8'(HB - 1 - i);
      sendFrame(8'h00, 0, 0);
      step(1'b0, 8'h00);
      nVec++; if (hvCyc.size() != 2) begin nMiss++; $display("FAIL b2b_hv_count got %0d want 2", hvCyc.size()); end
      else begin nVec++; if (hvCyc[1] - hvCyc[0] != 82) begin nMiss++; $display("FAIL b2b_spacing got %0d want 82", hvCyc[1] - hvCyc[0]); end end
      nVec++; if (bus.blockHeader[31:0] !== 32'h03020100) begin nMiss++; $display("FAIL b2b_last_word got %h want 03020100", bus.blockHeader[31:0]); end
      nVec++; if (cycleErr != e0) begin nMiss++; $display("FAIL b2b_trace got %0d bad cycles want 0", cycleErr - e0); end
   endtask

   task automatic test_reset_mid();
      int e0;
      sendByte(SYNC_BYTE, 0, 2);
      for (int i = 0; i < 40; i++) sendByte(8'($urandom), 0, 2);
      doReset();
      e0 = cycleErr;
      clearLogs();
      nVec++; if (bus.blockHeader !== '0) begin nMiss++; $display("FAIL mid_rst_header got %h want 0", bus.blockHeader[31:0]); end
      nVec++; if ({bus.header_valid, bus.frame_error, bus.timeout_error, bus.busy} !== 4'b0) begin nMiss++; $display("FAIL mid_rst_flags got %b want 0000", {bus.header_valid, bus.frame_error, bus.timeout_error, bus.busy}); end
      nVec++; if (bus.byteCount !== 32'd0) begin nMiss++; $display("FAIL mid_rst_count got %0d want 0", bus.byteCount); end
      for (int i = 0; i < HB; i++) pl[i] = 8'(i);
      sendFrame(8'h00, 0, 2);
      step(1'b0, 8'h00);
      nVec++; if (hvCyc.size() != 1 || feCyc.size() != 0 || toCyc.size() != 0) begin nMiss++; $display("FAIL mid_pulses got hv=%0d fe=%0d to=%0d want 1/0/0", hvCyc.size(), feCyc.size(), toCyc.size()); end
      nVec++; if (bus.byteCount !== 32'd82) begin nMiss++; $display("FAIL mid_count got %0d want 82", bus.byteCount); end
      nVec++; if (bus.blockHeader[31:0] !== 32'h4C4D4E4F) begin nMiss++; $display("FAIL mid_header got %h want 4C4D4E4F", bus.blockHeader[31:0]); end
      nVec++; if (cycleErr != e0) begin nMiss++; $display("FAIL mid_trace got %0d bad cycles want 0", cycleErr - e0); end
   endtask

   task automatic test_random();
      int e0 = cycleErr;
      int nGood = 0, nBad = 0, nTrunc = 0;
      clearLogs();
      for (int f = 0; f < 20; f++) begin
         int kind = $urandom_range(5, 0);
         int nGarb = $urandom_range(3, 0);
         for (int g = 0; g < nGarb; g++) begin
            logic [7:0] b = 8'($urandom);
            if (b == SYNC_BYTE) b = 8'h00;
            sendByte(b, 0, 3);
         end
         for (int i = 0; i < HB; i++) pl[i] = 8'($urandom);
         if (kind == 0) begin
            int k = $urandom_range(HB, 0);
            sendByte(SYNC_BYTE, 0, 3);
            for (int i = 0; i < k; i++) sendByte(pl[i], 0, 3);
            repeat (TMO + 5) step(1'b0, 8'h00);
            nTrunc++;
         end else if (kind == 1) begin
            sendFrame(plXor() ^ 8'($urandom_range(255, 1)), 0, 3);
            nBad++;
         end else begin
            sendFrame(plXor(), 0, 3);
            nGood++;
         end
      end
      step(1'b0, 8'h00);
      nVec++; if (hvCyc.size() != nGood) begin nMiss++; $display("FAIL rnd_hv got %0d want %0d", hvCyc.size(), nGood); end
      nVec++; if (feCyc.size() != nBad) begin nMiss++; $display("FAIL rnd_fe got %0d want %0d", feCyc.size(), nBad); end
      nVec++; if (toCyc.size() != nTrunc) begin nMiss++; $display("FAIL rnd_to got %0d want %0d", toCyc.size(), nTrunc); end
      nVec++; if (bus.blockHeader !== mHeader) begin nMiss++; $display("FAIL rnd_header got %h want %h", bus.blockHeader[31:0], mHeader[31:0]); end
      nVec++; if (cycleErr != e0) begin nMiss++; $display("FAIL rnd_trace got %0d bad cycles want 0", cycleErr - e0); end
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      reset        = 1'b1;
      modelReset();
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_timeout();
      test_garbage();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
